gshare_predictor: RTL
=====================

Name: gshare_predictor

Overview:
- Parametrised, superscalar gshare direction predictor.
- Sits beside the BTB between IF and EX. Predicts up to WIDTH conditional branches per cycle using PC xor global history.
- Speculatively updates global history and checkpoints it per branch. Trains PHT counters at resolve, and restores history on mispredict, flushing younger checkpoints.

Parameters:
- WIDTH, 2, fetch/resolve lanes per cycle.
- GHR_BITS, 6, global history length; PHT has 2**GHR_BITS entries.
- CKPT_DEPTH, 8, in-flight branch checkpoints (power of 2); CKPT_BITS = $clog2(CKPT_DEPTH).
- CTR_INIT, 2'b10, PHT counter reset value (weakly taken).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- if_valid  in  WIDTH  lane carries a valid instruction
- if_is_branch  in  WIDTH  lane is a conditional branch
- if_pc  in  WIDTH x 32  lane PC
- pred_taken  out  WIDTH  predicted direction per lane
- pred_tag  out  WIDTH x CKPT_BITS  checkpoint id allocated to the lane
- if_stall  out  1  insufficient free checkpoints; nothing allocated this cycle
- ex_valid  in  WIDTH  lane resolves a branch
- ex_tag  in  WIDTH x CKPT_BITS  checkpoint id of the resolving branch
- ex_taken  in  WIDTH  actual direction
- ex_mispredict  in  WIDTH  actual != predicted

Behaviour:
- Reset (async): ghr=0, all PHT=CTR_INIT, checkpoint valid/resolved bits clear, head=tail=0, count=0. Outputs settle to pred_taken=0, pred_tag=0, if_stall=0 while no IF lanes are valid.
- Index: idx_i = if_pc[i][GHR_BITS+1:2] ^ ghr_i.
  - ghr_0 = ghr.
  - ghr_{i+1} = {ghr_i[GHR_BITS-2:0], pred_i} if lane i is a counted branch, else ghr_i.
- Prediction: pred_i = PHT[idx_i][1], combinational, same cycle.
- Counted branch: if_valid & if_is_branch, and no older lane in the bundle predicted taken. Lanes younger than the first predicted-taken branch are dropped: pred_taken=0, no allocation.
- Allocation: n = number of counted branches.
  - If n > CKPT_DEPTH-count: if_stall=1 and nothing changes (all-or-nothing).
  - Otherwise each counted branch gets tag tail+k (k = lane-order rank, mod CKPT_DEPTH) and stores {ghr_i, idx_i}. At the edge, tail+=n, count+=n, ghr <= ghr_WIDTH.
  - pred_tag of non-counted lanes = 0.
- Resolve (each ex_valid lane, in lane order):
  - PHT[saved idx] performs a 2-bit saturating update toward ex_taken. Same-index updates in one cycle apply cumulatively in lane order.
  - The entry's resolved bit is set.
- Retire: each cycle head advances over consecutive resolved entries (up to WIDTH), clearing them; count decreases accordingly.
- Mispredict: oldest mispredicting lane relative to head wins, tag t.
  - ghr <= {saved_ghr[t][GHR_BITS-2:0], ex_taken}.
  - All entries younger than t invalidated; tail <= t+1; count recomputed.
  - Same-cycle IF allocation suppressed; if_stall=1 that cycle.
  - Resolves of entries younger than t in the same cycle are discarded; no PHT write.
- Resolve of an invalid tag: ignored.
- Wrap-around: head/tail modulo CKPT_DEPTH; full when count==CKPT_DEPTH.
- Reset mid-operation: immediate return to reset state; in-flight tags are meaningless afterward.

Decomposition:
- Package gshare_pkg:
  - ckpt_t {valid, resolved, ghr[GHR_BITS-1:0], idx[GHR_BITS-1:0]}.
  - Function sat2_update(ctr, taken).
  - Constants for counter encodings.
- Sub-module gshare_ckpt_buf: circular checkpoint buffer with multi-allocate, resolve-mark, in-order retire, flush-to-tag. Owns head/tail/count and drives free count.

Test Plan:
- Reset, lane0 branch pc=0x0000_0010, ghr=0 -> idx=4, pred_taken[0]=1 (CTR_INIT=10), pred_tag[0]=0; next cycle ghr=6'b000001.
- Same branch resolved not-taken twice, no mispredict flag -> PHT[4] goes 10->01->00; a later lookup at idx 4 predicts 0.
- Bundle: lane0 branch predicted taken, lane1 branch valid -> pred_taken[1]=0, only tag 0 allocated, count=1.
- Fill 8 checkpoints, then a 1-branch bundle -> if_stall=1, no allocation. Resolve tag 0 -> retire, next cycle allocation succeeds with tag 0 (wrap).
- Allocate tags 0..3 with ghr snapshots; ex_mispredict on tag 1 with ex_taken=1 and saved_ghr=6'b000011 -> ghr=6'b000111, tags 2,3 invalid, tail=2, if_stall=1 that cycle.
- Same cycle: lane0 mispredicts tag 2, lane1 mispredicts tag 1 -> tag 1 wins; tag 2 PHT update dropped.

Source files
------------

// File: rtl/gshare_pkg.sv
// Shared types and helpers for the gshare direction predictor.
// ckpt_t is sized by DEF_GHR_BITS, so an instance must keep GHR_BITS at that value.
package gshare_pkg;

    localparam int DEF_WIDTH      = 2;
    localparam int DEF_GHR_BITS   = 6;
    localparam int DEF_CKPT_DEPTH = 8;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                    valid;
        logic                    resolved;
        logic [DEF_GHR_BITS-1:0] ghr;
        logic [DEF_GHR_BITS-1:0] idx;
    } ckpt_t;

    function automatic logic [1:0] sat2_update(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
        else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/gshare_ckpt_buf.sv
// Circular checkpoint buffer: multi-allocate at tail, resolve marking,
// in-order retire from head and flush of everything younger than a tag.
module gshare_ckpt_buf
    import gshare_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CKPT_DEPTH = DEF_CKPT_DEPTH,
    parameter int CKPT_BITS  = $clog2(CKPT_DEPTH)
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic [WIDTH-1:0]                 i_alloc_en,
    input  logic [WIDTH-1:0][CKPT_BITS-1:0]  i_alloc_tag,
    input  ckpt_t [WIDTH-1:0]                i_alloc_data,
    input  logic [CKPT_BITS:0]               i_alloc_n,
    input  logic [WIDTH-1:0]                 i_res_en,
    input  logic [WIDTH-1:0][CKPT_BITS-1:0]  i_rd_tag,
    output ckpt_t [WIDTH-1:0]                o_rd_entry,
    input  logic                             i_flush_en,
    input  logic [CKPT_BITS-1:0]             i_flush_tag,
    output logic [CKPT_BITS-1:0]             o_head,
    output logic [CKPT_BITS-1:0]             o_tail,
    output logic [CKPT_BITS:0]               o_free
);

    ckpt_t                r_buf      [CKPT_DEPTH];
    ckpt_t                w_buf_next [CKPT_DEPTH];
    logic [CKPT_BITS-1:0] r_head;
    logic [CKPT_BITS-1:0] r_tail;
    logic [CKPT_BITS:0]   r_count;
    logic [CKPT_BITS:0]   w_ret;
    logic [CKPT_BITS-1:0] w_flush_age;

    assign w_flush_age = i_flush_tag - r_head;
    assign o_head      = r_head;
    assign o_tail      = r_tail;
    assign o_free      = (CKPT_BITS+1)'(CKPT_DEPTH) - r_count;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) o_rd_entry[i] = r_buf[i_rd_tag[i]];
    end

    // Order matters: resolve marks first, then retire/flush clears, then fresh allocations.
    always_comb begin : p_next
        logic                 v_stop;
        logic [CKPT_BITS-1:0] v_tag;
        w_buf_next = r_buf;
        w_ret      = '0;
        v_stop     = 1'b0;
        v_tag      = '0;
        for (int i = 0; i < WIDTH; i++)
            if (i_res_en[i]) w_buf_next[i_rd_tag[i]].resolved = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            v_tag = r_head + CKPT_BITS'(k);
            if (!v_stop && r_buf[v_tag].valid && r_buf[v_tag].resolved &&
                (!i_flush_en || CKPT_BITS'(k) <= w_flush_age)) begin
                w_buf_next[v_tag] = '0;
                w_ret = w_ret + (CKPT_BITS+1)'(1);
            end else begin
                v_stop = 1'b1;
            end
        end
        for (int j = 0; j < CKPT_DEPTH; j++)
            if (i_flush_en && (CKPT_BITS'(j) - r_head) > w_flush_age) w_buf_next[j] = '0;
        for (int i = 0; i < WIDTH; i++)
            if (i_alloc_en[i]) w_buf_next[i_alloc_tag[i]] = i_alloc_data[i];
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int j = 0; j < CKPT_DEPTH; j++) r_buf[j] <= '0;
        end else begin
            r_buf  <= w_buf_next;
            r_head <= r_head + w_ret[CKPT_BITS-1:0];
            if (i_flush_en) begin
                r_tail  <= i_flush_tag + CKPT_BITS'(1);
                r_count <= {1'b0, w_flush_age} + (CKPT_BITS+1)'(1) - w_ret;
            end else begin
                r_tail  <= r_tail + i_alloc_n[CKPT_BITS-1:0];
                r_count <= r_count - w_ret + i_alloc_n;
            end
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Superscalar gshare direction predictor with speculative global history,
// per-branch history checkpoints and mispredict recovery.
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int         WIDTH      = DEF_WIDTH,
    parameter int         GHR_BITS   = DEF_GHR_BITS,
    parameter int         CKPT_DEPTH = DEF_CKPT_DEPTH,
    parameter logic [1:0] CTR_INIT   = CTR_WT,
    localparam int        CKPT_BITS  = $clog2(CKPT_DEPTH)
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic [WIDTH-1:0]                 i_if_valid,
    input  logic [WIDTH-1:0]                 i_if_is_branch,
    input  logic [WIDTH-1:0][31:0]           i_if_pc,
    output logic [WIDTH-1:0]                 o_pred_taken,
    output logic [WIDTH-1:0][CKPT_BITS-1:0]  o_pred_tag,
    output logic                             o_if_stall,
    input  logic [WIDTH-1:0]                 i_ex_valid,
    input  logic [WIDTH-1:0][CKPT_BITS-1:0]  i_ex_tag,
    input  logic [WIDTH-1:0]                 i_ex_taken,
    input  logic [WIDTH-1:0]                 i_ex_mispredict
);

    localparam int PHT_SIZE = 2 ** GHR_BITS;

    logic [GHR_BITS-1:0]  r_ghr;
    logic [1:0]           r_pht      [PHT_SIZE];
    logic [1:0]           w_pht_next [PHT_SIZE];
    logic [GHR_BITS-1:0]  w_idx      [WIDTH];
    logic [GHR_BITS-1:0]  w_ghr_spec;
    logic [WIDTH-1:0]     w_counted;
    logic [CKPT_BITS:0]   w_n;
    ckpt_t [WIDTH-1:0]    w_alloc_data;
    ckpt_t [WIDTH-1:0]    w_rd_entry;
    logic [CKPT_BITS-1:0] w_age      [WIDTH];
    logic [WIDTH-1:0]     w_res_en;
    logic                 w_mp_any;
    logic [CKPT_BITS-1:0] w_mp_age;
    logic [CKPT_BITS-1:0] w_mp_tag;
    logic                 w_mp_taken;
    logic [GHR_BITS-2:0]  w_mp_ghr;
    logic [CKPT_BITS-1:0] w_head;
    logic [CKPT_BITS-1:0] w_tail;
    logic [CKPT_BITS:0]   w_free;
    logic                 w_unused;

    assign w_unused = ^{i_if_pc, w_rd_entry};

    // Lane history chains through the bundle; lanes after the first predicted-taken branch drop out.
    always_comb begin : p_fetch
        logic [GHR_BITS-1:0] v_ghr;
        logic                v_taken_seen;
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        v_ghr        = r_ghr;
        v_taken_seen = 1'b0;
        w_n          = '0;
        w_counted    = '0;
        o_pred_taken = '0;
        o_pred_tag   = '0;
        w_alloc_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_idx[i] = i_if_pc[i][GHR_BITS+1:2] ^ v_ghr;
            if (i_if_valid[i] && i_if_is_branch[i] && !v_taken_seen) begin
                w_counted[i]    = 1'b1;
                o_pred_taken[i] = r_pht[w_idx[i]][1];
                o_pred_tag[i]   = w_tail + w_n[CKPT_BITS-1:0];
                w_alloc_data[i] = '{valid: 1'b1, resolved: 1'b0, ghr: v_ghr, idx: w_idx[i]};
                v_ghr           = {v_ghr[GHR_BITS-2:0], o_pred_taken[i]};
                v_taken_seen    = o_pred_taken[i];
                w_n             = w_n + (CKPT_BITS+1)'(1);
            end
        end
        w_ghr_spec = v_ghr;
    end

    // Oldest valid mispredicting lane, measured as distance from head.
    always_comb begin
        w_mp_any   = 1'b0;
        w_mp_age   = '0;
        w_mp_tag   = '0;
        w_mp_taken = 1'b0;
        w_mp_ghr   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_age[i] = i_ex_tag[i] - w_head;
            if (i_ex_valid[i] && i_ex_mispredict[i] && w_rd_entry[i].valid &&
                (!w_mp_any || w_age[i] < w_mp_age)) begin
                w_mp_any   = 1'b1;
                w_mp_age   = w_age[i];
                w_mp_tag   = i_ex_tag[i];
                w_mp_taken = i_ex_taken[i];
                w_mp_ghr   = w_rd_entry[i].ghr[GHR_BITS-2:0];
            end
        end
    end

    always_comb begin
        w_pht_next = r_pht;
        w_res_en   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_ex_valid[i] && w_rd_entry[i].valid && (!w_mp_any || w_age[i] <= w_mp_age)) begin
                w_res_en[i] = 1'b1;
                w_pht_next[w_rd_entry[i].idx] = sat2_update(w_pht_next[w_rd_entry[i].idx], i_ex_taken[i]);
            end
        end
    end

    assign o_if_stall = w_mp_any || (w_n > w_free);

    gshare_ckpt_buf #(
        .WIDTH      (WIDTH),
        .CKPT_DEPTH (CKPT_DEPTH),
        .CKPT_BITS  (CKPT_BITS)
    ) u_ckpt (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_alloc_en   (w_counted & {WIDTH{~o_if_stall}}),
        .i_alloc_tag  (o_pred_tag),
        .i_alloc_data (w_alloc_data),
        .i_alloc_n    (o_if_stall ? '0 : w_n),
        .i_res_en     (w_res_en),
        .i_rd_tag     (i_ex_tag),
        .o_rd_entry   (w_rd_entry),
        .i_flush_en   (w_mp_any),
        .i_flush_tag  (w_mp_tag),
        .o_head       (w_head),
        .o_tail       (w_tail),
        .o_free       (w_free)
    );

    // NOTE: the PHT is flops, not a RAM macro, because every counter must reset to CTR_INIT.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ghr <= '0;
            for (int k = 0; k < PHT_SIZE; k++) r_pht[k] <= CTR_INIT;
        end else begin
            r_pht <= w_pht_next;
            if (w_mp_any)         r_ghr <= {w_mp_ghr, w_mp_taken};
            else if (!o_if_stall) r_ghr <= w_ghr_spec;
        end
    end

endmodule
